tl_a_req_gen: RTL and testbench

TileLink A-channel request generator. It turns single-command memory requests (read or write, size, address) plus a separate write-data beat stream into legal A-channel beats: Get, PutFullData or PutPartialData. It sits directly upstream of the 2-entry A-channel buffer queue and drives that queue's enqueue port. The queue fills param, source and corrupt with zero, so this block does not produce them.

---
 rtl/tl_a_req_gen_if.sv | 61 ++++++
 rtl/tl_a_req_gen.sv | 106 ++++++++++
 tb/tb_tl_a_req_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_a_req_gen_if.sv
// Request-side bundle of the TileLink A-channel request generator:
// command port, write-data beat stream and A-channel enqueue port.
interface tl_a_req_gen_if;
  logic        cmd_ready;
  logic        cmd_valid;
  logic        cmd_write;
  logic        cmd_partial;
  logic [3:0]  cmd_size;
  logic [32:0] cmd_address;
  logic        wdata_ready;
  logic        wdata_valid;
  logic [63:0] wdata_data;
  logic [7:0]  wdata_strb;
  logic        a_ready;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [3:0]  a_size;
  logic [32:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;

  modport master (
    output cmd_ready,
    input  cmd_valid,
    input  cmd_write,
    input  cmd_partial,
    input  cmd_size,
    input  cmd_address,
    output wdata_ready,
    input  wdata_valid,
    input  wdata_data,
    input  wdata_strb,
    input  a_ready,
    output a_valid,
    output a_opcode,
    output a_size,
    output a_address,
    output a_mask,
    output a_data
  );

  modport slave (
    input  cmd_ready,
    output cmd_valid,
    output cmd_write,
    output cmd_partial,
    output cmd_size,
    output cmd_address,
    input  wdata_ready,
    output wdata_valid,
    output wdata_data,
    output wdata_strb,
    output a_ready,
    input  a_valid,
    input  a_opcode,
    input  a_size,
    input  a_address,
    input  a_mask,
    input  a_data
  );
endinterface

// File: rtl/tl_a_req_gen.sv
// TileLink A-channel request generator: turns a command plus a
// write-data beat stream into Get / PutFullData / PutPartialData beats.
module tl_a_req_gen #(
  parameter int unsigned MAX_SIZE = 6
) (
  input  logic           clock,
  input  logic           reset,
  tl_a_req_gen_if.master bus,
  output logic           busy,
  output logic           err
);

  typedef enum logic [1:0] {
    IDLE,
    ERR,
    BEAT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  opcode_q;
  logic [3:0]  size_q;
  logic [32:0] addr_q;
  logic [7:0]  base_q;
  logic [3:0]  cnt_q;

  logic        accept;
  logic        legal;
  logic        is_put;
  logic        fire;
  logic [32:0] align_mask;
  logic [3:0]  beats;
  logic [7:0]  base_mask;
  logic [2:0]  opcode_d;

  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign is_put = ~opcode_q[2];

  always_comb begin
    align_mask = (33'd1 << bus.cmd_size) - 33'd1;
    legal = (32'(bus.cmd_size) <= MAX_SIZE)
         && ((bus.cmd_address & align_mask) == '0);
    beats = 4'd1;
    if (bus.cmd_write && bus.cmd_size > 4'd3)
      beats = 4'd1 << (bus.cmd_size - 4'd3);
    // sub-word sizes select a byte lane group inside the 8-byte beat
    base_mask = 8'hFF;
    unique case (1'b1)
      (bus.cmd_size == 4'd0): base_mask = 8'h01 << bus.cmd_address[2:0];
      (bus.cmd_size == 4'd1): base_mask = 8'h03 << bus.cmd_address[2:0];
      (bus.cmd_size == 4'd2): base_mask = 8'h0F << bus.cmd_address[2:0];
      default:                base_mask = 8'hFF;
    endcase
    opcode_d = 3'd4;
    if (bus.cmd_write)
      opcode_d = bus.cmd_partial ? 3'd1 : 3'd0;
  end

  always_comb begin
    bus.cmd_ready   = (state_q == IDLE);
    bus.a_valid     = (state_q == BEAT) && (!is_put || bus.wdata_valid);
    bus.wdata_ready = (state_q == BEAT) && is_put && bus.a_ready;
    fire            = bus.a_valid & bus.a_ready;
    busy            = (state_q != IDLE);
    err             = (state_q == ERR);
    state_d         = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = legal ? BEAT : ERR;
      ERR:  state_d = IDLE;
      BEAT: if (fire && cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode_q <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      opcode_q <= opcode_d;
      size_q   <= bus.cmd_size;
      addr_q   <= bus.cmd_address;
      base_q   <= base_mask;
      cnt_q    <= legal ? beats : 4'd0;
    end else if (fire) begin
      cnt_q    <= cnt_q - 4'd1;
    end
  end

  assign bus.a_opcode  = opcode_q;
  assign bus.a_size    = size_q;
  assign bus.a_address = addr_q;
  assign bus.a_mask    = (opcode_q == 3'd1) ? (base_q & bus.wdata_strb)
                                            : base_q;
  assign bus.a_data    = ((state_q == BEAT) && is_put) ? bus.wdata_data
                                                       : 64'd0;

endmodule

// File: tb/tb_tl_a_req_gen.sv
// Directed bench for tl_a_req_gen: one task per scenario with
// hand-computed expectations and inline comparisons.
module tb_tl_a_req_gen;
  logic clock;
  logic reset;
  logic busy;
  logic err;
  int   n_cmp;
  int   n_fail;

  tl_a_req_gen_if bus ();

  tl_a_req_gen #(.MAX_SIZE(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master),
    .busy  (busy),
    .err   (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic part,
                          input logic [3:0] sz, input logic [32:0] ad);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = wr;
    bus.cmd_partial = part;
    bus.cmd_size    = sz;
    bus.cmd_address = ad;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got %0b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid got %0b want 0", bus.a_valid); end
    n_cmp++; if (bus.wdata_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wdata_ready got %0b want 0", bus.wdata_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0b want 0", err); end
    n_cmp++; if (bus.a_opcode !== 3'd0) begin n_fail++; $display("FAIL rst_opcode got %0d want 0", bus.a_opcode); end
    n_cmp++; if (bus.a_address !== 33'd0) begin n_fail++; $display("FAIL rst_address got %h want 0", bus.a_address); end
    n_cmp++; if (bus.a_mask !== 8'h00) begin n_fail++; $display("FAIL rst_mask got %h want 00", bus.a_mask); end
    n_cmp++; if (bus.a_data !== 64'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", bus.a_data); end
    step();
  endtask

  task automatic test_get();
    bus.a_ready = 1'b1;
    send_cmd(1'b0, 1'b0, 4'd2, 33'h1_0000_0004);
    @(negedge clock);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL get_cmd_ready_T got %0b want 1", bus.cmd_ready); end
    step();
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL get_valid got %0b want 1", bus.a_valid); end
    n_cmp++; if (bus.a_opcode !== 3'd4) begin n_fail++; $display("FAIL get_opcode got %0d want 4", bus.a_opcode); end
    n_cmp++; if (bus.a_mask !== 8'hF0) begin n_fail++; $display("FAIL get_mask got %h want f0", bus.a_mask); end
    n_cmp++; if (bus.a_data !== 64'd0) begin n_fail++; $display("FAIL get_data got %h want 0", bus.a_data); end
    n_cmp++; if (bus.a_address !== 33'h1_0000_0004) begin n_fail++; $display("FAIL get_address got %h want 100000004", bus.a_address); end
    n_cmp++; if (bus.a_size !== 4'd2) begin n_fail++; $display("FAIL get_size got %0d want 2", bus.a_size); end
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL get_cmd_ready_T1 got %0b want 0", bus.cmd_ready); end
    step();
    @(negedge clock);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL get_cmd_ready_T2 got %0b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL get_one_beat got %0b want 0", bus.a_valid); end
    step();
  endtask

  task automatic test_put_full();
    bus.a_ready     = 1'b1;
    bus.wdata_valid = 1'b1;
    bus.wdata_data  = 64'd0;
    send_cmd(1'b1, 1'b0, 4'd6, 33'h40);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_cmp++; if (bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL pf_valid beat %0d got %0b want 1", i, bus.a_valid); end
      n_cmp++; if (bus.wdata_ready !== 1'b1) begin n_fail++; $display("FAIL pf_wready beat %0d got %0b want 1", i, bus.wdata_ready); end
      n_cmp++; if (bus.a_opcode !== 3'd0) begin n_fail++; $display("FAIL pf_opcode beat %0d got %0d want 0", i, bus.a_opcode); end
      n_cmp++; if (bus.a_mask !== 8'hFF) begin n_fail++; $display("FAIL pf_mask beat %0d got %h want ff", i, bus.a_mask); end
      n_cmp++; if (bus.a_address !== 33'h40) begin n_fail++; $display("FAIL pf_address beat %0d got %h want 40", i, bus.a_address); end
      n_cmp++; if (bus.a_data !== 64'(i)) begin n_fail++; $display("FAIL pf_data beat %0d got %h want %h", i, bus.a_data, i); end
      step();
      bus.wdata_data = 64'(i + 1);
    end
    bus.wdata_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL pf_end_valid got %0b want 0", bus.a_valid); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pf_end_cmd_ready got %0b want 1", bus.cmd_ready); end
    step();
  endtask

  task automatic test_put_partial();
    bus.a_ready     = 1'b1;
    bus.wdata_valid = 1'b1;
    bus.wdata_data  = 64'hDEAD_BEEF_0123_4567;
    bus.wdata_strb  = 8'h0F;
    send_cmd(1'b1, 1'b1, 4'd3, 33'h8);
    step();
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL pp_valid got %0b want 1", bus.a_valid); end
    n_cmp++; if (bus.a_opcode !== 3'd1) begin n_fail++; $display("FAIL pp_opcode got %0d want 1", bus.a_opcode); end
    n_cmp++; if (bus.a_mask !== 8'h0F) begin n_fail++; $display("FAIL pp_mask got %h want 0f", bus.a_mask); end
    n_cmp++; if (bus.a_data !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL pp_data got %h want deadbeef01234567", bus.a_data); end
    step();
    bus.wdata_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL pp_one_beat got %0b want 0", bus.a_valid); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pp_cmd_ready got %0b want 1", bus.cmd_ready); end
    step();
  endtask

  task automatic test_backpressure();
    logic ar_pat [10] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};
    logic wv_pat [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    logic ar;
    logic wv;
    int   k;
    bus.wdata_strb = 8'h00;
    send_cmd(1'b1, 1'b0, 4'd5, 33'h20);
    step();
    bus.cmd_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      ar = (c < 10) ? ar_pat[c] : 1'b1;
      wv = (c < 10) ? wv_pat[c] : 1'b1;
      bus.a_ready     = ar;
      bus.wdata_valid = wv;
      bus.wdata_data  = 64'hA0 + 64'(k);
      @(negedge clock);
      n_cmp++; if (bus.a_valid !== wv) begin n_fail++; $display("FAIL bp_valid cyc %0d got %0b want %0b", c, bus.a_valid, wv); end
      n_cmp++; if (bus.wdata_ready !== ar) begin n_fail++; $display("FAIL bp_wready cyc %0d got %0b want %0b", c, bus.wdata_ready, ar); end
      n_cmp++; if (bus.a_address !== 33'h20) begin n_fail++; $display("FAIL bp_address cyc %0d got %h want 20", c, bus.a_address); end
      n_cmp++; if (bus.a_size !== 4'd5) begin n_fail++; $display("FAIL bp_size cyc %0d got %0d want 5", c, bus.a_size); end
      n_cmp++; if (bus.a_mask !== 8'hFF) begin n_fail++; $display("FAIL bp_mask cyc %0d got %h want ff", c, bus.a_mask); end
      if (wv) begin
        n_cmp++; if (bus.a_data !== 64'hA0 + 64'(k)) begin n_fail++; $display("FAIL bp_data cyc %0d got %h want %h", c, bus.a_data, 64'hA0 + 64'(k)); end
      end
      if (wv && ar) k++;
      step();
    end
    n_cmp++; if (k != 4) begin n_fail++; $display("FAIL bp_beat_count got %0d want 4", k); end
    bus.wdata_valid = 1'b1;
    bus.a_ready     = 1'b1;
    @(negedge clock);
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra_beat got %0b want 0", bus.a_valid); end
    n_cmp++; if (bus.wdata_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra_wready got %0b want 0", bus.wdata_ready); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_cmd_ready got %0b want 1", bus.cmd_ready); end
    bus.wdata_valid = 1'b0;
    step();
  endtask

  task automatic test_errors();
    bus.a_ready = 1'b1;
    send_cmd(1'b1, 1'b0, 4'd7, 33'h0);
    step();
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_size_pulse got %0b want 1", err); end
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL err_size_valid got %0b want 0", bus.a_valid); end
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL err_size_cmd_ready_T1 got %0b want 0", bus.cmd_ready); end
    step();
    @(negedge clock);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_size_one_cycle got %0b want 0", err); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL err_size_cmd_ready_T2 got %0b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL err_size_valid_T2 got %0b want 0", bus.a_valid); end
    send_cmd(1'b0, 1'b0, 4'd3, 33'h4);
    step();
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_align_pulse got %0b want 1", err); end
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL err_align_valid got %0b want 0", bus.a_valid); end
    step();
    @(negedge clock);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_align_one_cycle got %0b want 0", err); end
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL err_align_valid_T2 got %0b want 0", bus.a_valid); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL err_align_cmd_ready got %0b want 1", bus.cmd_ready); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    bus.a_ready     = 1'b1;
    bus.wdata_valid = 1'b1;
    bus.wdata_data  = 64'h11;
    send_cmd(1'b1, 1'b0, 4'd6, 33'h80);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_cmp++; if (bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL rm_valid beat %0d got %0b want 1", i, bus.a_valid); end
      step();
    end
    reset = 1'b1;
    step();
    @(negedge clock);
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid_after got %0b want 0", bus.a_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_after got %0b want 0", busy); end
    n_cmp++; if (bus.wdata_ready !== 1'b0) begin n_fail++; $display("FAIL rm_wready_after got %0b want 0", bus.wdata_ready); end
    reset = 1'b0;
    bus.wdata_valid = 1'b0;
    step();
    send_cmd(1'b0, 1'b0, 4'd3, 33'h18);
    step();
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.a_valid !== 1'b1) begin n_fail++; $display("FAIL rm_get_valid got %0b want 1", bus.a_valid); end
    n_cmp++; if (bus.a_opcode !== 3'd4) begin n_fail++; $display("FAIL rm_get_opcode got %0d want 4", bus.a_opcode); end
    n_cmp++; if (bus.a_mask !== 8'hFF) begin n_fail++; $display("FAIL rm_get_mask got %h want ff", bus.a_mask); end
    n_cmp++; if (bus.a_address !== 33'h18) begin n_fail++; $display("FAIL rm_get_address got %h want 18", bus.a_address); end
    n_cmp++; if (bus.a_data !== 64'd0) begin n_fail++; $display("FAIL rm_get_data got %h want 0", bus.a_data); end
    step();
    @(negedge clock);
    n_cmp++; if (bus.a_valid !== 1'b0) begin n_fail++; $display("FAIL rm_get_one_beat got %0b want 0", bus.a_valid); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_get_cmd_ready got %0b want 1", bus.cmd_ready); end
    step();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_partial = 1'b0;
    bus.cmd_size    = 4'd0;
    bus.cmd_address = 33'd0;
    bus.wdata_valid = 1'b0;
    bus.wdata_data  = 64'd0;
    bus.wdata_strb  = 8'h00;
    bus.a_ready     = 1'b0;
    test_reset();
    test_get();
    test_put_full();
    test_put_partial();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
